seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle shift/add/sub/logic ops, iterative
// shift-add multiply and restoring divide, valid/ready handshakes.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       alu_opsel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result_l,
    output logic [WIDTH-1:0] alu_result_h,
    output logic             ovf_flag,
    output logic             cf_flag,
    output logic             zero_flag_l,
    output logic             zero_flag_h,
    output logic             dbz_flag,
    output logic             ill_flag
);

    localparam int SA_W = $clog2(WIDTH);

    localparam logic [2:0] CLS_SHIFT  = 3'b000;
    localparam logic [2:0] CLS_ADDSUB = 3'b001;
    localparam logic [2:0] CLS_MUL    = 3'b010;
    localparam logic [2:0] CLS_DIV    = 3'b011;
    localparam logic [2:0] CLS_LOGIC  = 3'b100;

    // Counter value on the final multiply/divide iteration.
    localparam logic [SA_W-1:0] LAST_ITER = SA_W'(WIDTH - 1);
    // WIDTH expressed in SA_W+1 bits, used for the rotate's right-shift leg.
    localparam logic [SA_W:0]   W_FULL    = (SA_W + 1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Barrel shifter for the four shift sub-ops, full WIDTH result.
    function automatic logic [WIDTH-1:0] shift_fn(
        input logic [1:0]       sub,
        input logic [WIDTH-1:0] b,
        input logic [SA_W-1:0]  sa
    );
        logic signed [WIDTH-1:0] b_s;
        logic        [SA_W:0]    rsh;
        b_s = b;
        // A zero amount gives rsh == WIDTH, which shifts everything out,
        // so ROL by 0 returns b unchanged.
        rsh = W_FULL - {1'b0, sa};
        case (sub)
            2'b00:   shift_fn = b << sa;
            2'b01:   shift_fn = b >> sa;
            2'b10:   shift_fn = b_s >>> sa;
            default: shift_fn = (b << sa) | (b >> rsh);
        endcase
    endfunction

    // Add or subtract; returns {carry/borrow, signed overflow, result}.
    function automatic logic [WIDTH+1:0] addsub_fn(
        input logic                    sub_en,
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic [WIDTH:0] r;
        logic           ovf;
        if (sub_en) begin
            r   = {1'b0, a} - {1'b0, b};
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        end else begin
            r   = {1'b0, a} + {1'b0, b};
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        end
        return {r[WIDTH], ovf, r[WIDTH-1:0]};
    endfunction

    state_t            state_q, state_d;
    logic [SA_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d;       // partial product / partial remainder
    logic [WIDTH-1:0]  lo_q, lo_d;       // multiplier -> product low / dividend -> quotient
    logic [WIDTH-1:0]  opnd_q, opnd_d;   // multiplicand / divisor
    logic              is_div_q, is_div_d;
    logic [WIDTH-1:0]  res_l_q, res_l_d;
    logic [WIDTH-1:0]  res_h_q, res_h_d;
    logic              ovf_q, ovf_d;
    logic              cf_q, cf_d;
    logic              dbz_q, dbz_d;
    logic              ill_q, ill_d;

    logic [WIDTH-1:0]  sc_l;
    logic              sc_ovf, sc_cf, sc_ill, sc_multi, sc_div;
    logic [WIDTH+1:0]  as_r;

    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shl;
    logic              div_neg;
    logic [WIDTH-1:0]  div_diff;
    logic [WIDTH-1:0]  iter_hi, iter_lo;

    // Decode the presented opsel and compute every single-cycle result.
    always_comb begin
        sc_l     = '0;
        sc_ovf   = 1'b0;
        sc_cf    = 1'b0;
        sc_ill   = 1'b0;
        sc_multi = 1'b0;
        sc_div   = 1'b0;
        as_r     = addsub_fn(alu_opsel[0], op_a, op_b);
        case (alu_opsel[4:2])
            CLS_SHIFT: sc_l = shift_fn(alu_opsel[1:0], op_b, op_a[SA_W-1:0]);
            CLS_ADDSUB: begin
                if (!alu_opsel[1]) begin
                    sc_cf  = as_r[WIDTH+1];
                    sc_ovf = as_r[WIDTH];
                    sc_l   = as_r[WIDTH-1:0];
                end else begin
                    sc_ill = 1'b1;
                end
            end
            CLS_MUL: begin
                if (alu_opsel[1:0] == 2'b00) sc_multi = 1'b1;
                else                         sc_ill   = 1'b1;
            end
            CLS_DIV: begin
                if (alu_opsel[1:0] == 2'b00) begin
                    sc_multi = 1'b1;
                    sc_div   = 1'b1;
                end else begin
                    sc_ill = 1'b1;
                end
            end
            CLS_LOGIC: begin
                case (alu_opsel[1:0])
                    2'b00:   sc_l = op_a & op_b;
                    2'b01:   sc_l = op_a | op_b;
                    2'b10:   sc_l = op_a ^ op_b;
                    default: sc_l = ~(op_a | op_b);
                endcase
            end
            default: sc_ill = 1'b1;
        endcase
    end

    // One multiply (shift-add) or divide (restoring) iteration.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shl  = {hi_q, lo_q[WIDTH-1]};
        div_neg  = div_shl < {1'b0, opnd_q};
        div_diff = div_shl[WIDTH-1:0] - opnd_q;
        if (is_div_q) begin
            iter_hi = div_neg ? div_shl[WIDTH-1:0] : div_diff;
            iter_lo = {lo_q[WIDTH-2:0], ~div_neg};
        end else begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Next-state and register-update logic for the IDLE/CALC/DONE FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        res_l_d  = res_l_q;
        res_h_d  = res_h_q;
        ovf_d    = ovf_q;
        cf_d     = cf_q;
        dbz_d    = dbz_q;
        ill_d    = ill_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ovf_d   = sc_ovf;
                    cf_d    = sc_cf;
                    ill_d   = sc_ill;
                    res_h_d = '0;
                    if (sc_multi) begin
                        state_d  = CALC;
                        cnt_d    = '0;
                        hi_d     = '0;
                        lo_d     = op_a;
                        opnd_d   = op_b;
                        is_div_d = sc_div;
                        dbz_d    = sc_div && (op_b == '0);
                        res_l_d  = '0;
                    end else begin
                        state_d = DONE;
                        dbz_d   = 1'b0;
                        res_l_d = sc_l;
                    end
                end
            end
            CALC: begin
                hi_d  = iter_hi;
                lo_d  = iter_lo;
                cnt_d = cnt_q + SA_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    res_l_d = iter_lo;
                    res_h_d = iter_hi;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Iteration, result and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            res_l_q  <= '0;
            res_h_q  <= '0;
            ovf_q    <= 1'b0;
            cf_q     <= 1'b0;
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            res_l_q  <= res_l_d;
            res_h_q  <= res_h_d;
            ovf_q    <= ovf_d;
            cf_q     <= cf_d;
            dbz_q    <= dbz_d;
            ill_q    <= ill_d;
        end
    end

    // Outputs are forced to zero whenever no result is being presented.
    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign alu_result_l = out_valid ? res_l_q : '0;
    assign alu_result_h = out_valid ? res_h_q : '0;
    assign ovf_flag     = out_valid & ovf_q;
    assign cf_flag      = out_valid & cf_q;
    assign dbz_flag     = out_valid & dbz_q;
    assign ill_flag     = out_valid & ill_q;
    assign zero_flag_l  = out_valid & (res_l_q == '0);
    assign zero_flag_h  = out_valid & (res_h_q == '0);

endmodule
